// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two combinational read ports and
// one synchronous write port. Register 0 is hardwired to zero. Registers 29
// ($sp) and 31 ($ra) take parameterised reset values; all others reset to 0.
// WriteAck pulses for one cycle after each accepted write to a nonzero register.
// Optional feature: define REG_FILE_BYPASS_EN to forward WriteData to a read
// port in the same cycle as a matching write (never for register 0).
module reg_file #(
   parameter logic [31:0] SP_INIT = 32'd227,
   parameter logic [31:0] RA_INIT = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWrite,
   input  logic [4:0]  ReadReg1,
   input  logic [4:0]  ReadReg2,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   output logic        WriteAck
);

   localparam int unsigned NUM_REGS = 32;

   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] regs_d [NUM_REGS];
   logic        write_ack_q;
   logic        write_ack_d;
   logic        wr_en;

   function automatic logic [31:0] reset_value(input int unsigned idx);
      logic [31:0] val;
      val = '0;
      if (idx == 29) val = SP_INIT;
      if (idx == 31) val = RA_INIT;
      return val;
   endfunction

   assign wr_en = RegWrite && (WriteReg != 5'd0);

   // Next-state: copy current contents, overlay the accepted write.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en) begin
         regs_d[WriteReg] = WriteData;
      end
      write_ack_d = wr_en;
   end

   // State registers with asynchronous reset to the architectural defaults.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= reset_value(i);
         end
         write_ack_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         write_ack_q <= write_ack_d;
      end
   end

   // Read port A: zero for register 0, optional same-cycle forwarding.
   always_comb begin
      ReadData1 = (ReadReg1 == 5'd0) ? '0 : regs_q[ReadReg1];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (ReadReg1 == WriteReg)) begin
         ReadData1 = WriteData;
      end
`endif
   end

   // Read port B: zero for register 0, optional same-cycle forwarding.
   always_comb begin
      ReadData2 = (ReadReg2 == 5'd0) ? '0 : regs_q[ReadReg2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (ReadReg2 == WriteReg)) begin
         ReadData2 = WriteData;
      end
`endif
   end

   assign WriteAck = write_ack_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed, table-driven self-checking bench for reg_file.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        WriteAck;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   reg_file #(
      .SP_INIT(32'd227),
      .RA_INIT(32'd0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .WriteAck  (WriteAck)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
      logic        exp_ack;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Hard bound on total simulation time.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] bypass_exp;

      // Writes apply on the edge; reads are taken after the edge with RegWrite low.
      vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
      vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
      vecs[2] = '{1'b0, 5'd8,  32'hFFFFFFFF, 5'd8,  5'd29, 32'hDEADBEEF, 32'd227,      1'b0};
      vecs[3] = '{1'b1, 5'd29, 32'h000000AA, 5'd29, 5'd8,  32'hAA,       32'hDEADBEEF, 1'b1};
      vecs[4] = '{1'b1, 5'd31, 32'h00000400, 5'd31, 5'd0,  32'h400,      32'h0,        1'b1};
      vecs[5] = '{1'b1, 5'd5,  32'h00000005, 5'd5,  5'd31, 32'h5,        32'h400,      1'b1};
      vecs[6] = '{1'b1, 5'd8,  32'h00000001, 5'd8,  5'd5,  32'h1,        32'h5,        1'b1};
      vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd8,  32'h0,        32'h1,        1'b0};

      // Reset state, visible before any clock edge.
      reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      ReadReg1 = 5'd29; ReadReg2 = 5'd31;
      #1;
      check("rst_r29", ReadData1, 32'd227);
      check("rst_r31", ReadData2, 32'd0);
      check("rst_ack", {31'b0, WriteAck}, 32'd0);
      ReadReg1 = 5'd5;
      #1;
      check("rst_r5", ReadData1, 32'd0);

      // A write across an edge while reset is held is discarded.
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h99;
      @(posedge clk); #1;
      RegWrite = 1'b0; ReadReg1 = 5'd8;
      #1;
      check("rst_wr_discard", ReadData1, 32'd0);
      check("rst_wr_ack", {31'b0, WriteAck}, 32'd0);

      // Release reset; first write after release lands on the next edge.
      reset = 1'b0;
      ReadReg1 = 5'd31; ReadReg2 = 5'd31;
      RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h400;
      #1;
`ifdef REG_FILE_BYPASS_EN
      bypass_exp = 32'h400;
`else
      bypass_exp = 32'h0;
`endif
      check("bypass_pre_edge", ReadData2, bypass_exp);
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      check("bypass_post_rd1", ReadData1, 32'h400);
      check("bypass_post_rd2", ReadData2, 32'h400);
      check("first_write_ack", {31'b0, WriteAck}, 32'd1);

      // Register 0 is never forwarded nor written.
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF;
      ReadReg1 = 5'd0; ReadReg2 = 5'd0;
      #1;
      check("r0_nofwd_rd1", ReadData1, 32'd0);
      check("r0_nofwd_rd2", ReadData2, 32'd0);
      @(posedge clk); #1;
      RegWrite = 1'b0;
      #1;
      check("r0_after_edge", ReadData1, 32'd0);
      check("r0_ack", {31'b0, WriteAck}, 32'd0);

      // Table-driven vectors.
      for (int i = 0; i < 8; i++) begin
         RegWrite = vecs[i].we; WriteReg = vecs[i].wa; WriteData = vecs[i].wd;
         @(posedge clk); #1;
         RegWrite = 1'b0;
         ReadReg1 = vecs[i].ra1; ReadReg2 = vecs[i].ra2;
         #1;
         check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].exp1);
         check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].exp2);
         check($sformatf("vec%0d_ack", i), {31'b0, WriteAck}, {31'b0, vecs[i].exp_ack});
      end

      // Back-to-back writes to registers 1..31: ack held continuously.
      for (int unsigned i = 1; i < 32; i++) begin
         RegWrite = 1'b1; WriteReg = 5'(i); WriteData = i;
         @(posedge clk); #1;
         check($sformatf("sweep_ack%0d", i), {31'b0, WriteAck}, 32'd1);
      end
      RegWrite = 1'b0;
      for (int unsigned i = 1; i < 32; i++) begin
         ReadReg1 = 5'(i); ReadReg2 = 5'(i);
         #1;
         check($sformatf("sweep_rd1_%0d", i), ReadData1, i);
         check($sformatf("sweep_rd2_%0d", i), ReadData2, i);
      end

      // Reset asserted mid-cycle restores defaults without a clock edge.
      @(posedge clk); #1;
      RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'hAA;
      @(posedge clk); #1;
      RegWrite = 1'b0; ReadReg1 = 5'd29; ReadReg2 = 5'd8;
      #1;
      check("mid_pre_r29", ReadData1, 32'hAA);
      check("mid_pre_ack", {31'b0, WriteAck}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_r29", ReadData1, 32'd227);
      check("mid_rst_r8", ReadData2, 32'd0);
      check("mid_rst_ack", {31'b0, WriteAck}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'd227, meaning the reset value of register 29 ($sp).
REQ-002 SHALL have parameter RA_INIT, default 32'd0, meaning the reset value of register 31 ($ra).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port RegWrite, input, 1, write enable.
REQ-006 SHALL have port ReadReg1, input, 5, read port A address (rs).
REQ-007 SHALL have port ReadReg2, input, 5, read port B address (rt).
REQ-008 SHALL have port WriteReg, input, 5, write address, driven by the write-register select mux (rt / 29 / 31 / rd).
REQ-009 SHALL have port WriteData, input, 32, write data.
REQ-010 SHALL have port ReadData1, output, 32, data for ReadReg1.
REQ-011 SHALL have port ReadData2, output, 32, data for ReadReg2.
REQ-012 SHALL have port WriteAck, output, 1, high for one cycle after each accepted write to a nonzero register.

Function
REQ-013 SHALL hold 32 registers of 32 bits, indexed 0..31.
REQ-014 SHALL write WriteData into register WriteReg on a rising clk edge when RegWrite=1 and reset=0; write latency is one edge.
REQ-015 SHALL ignore writes to register 0; register 0 SHALL always read 32'd0.
REQ-016 SHALL drive ReadData1/ReadData2 combinationally from the addressed register, with zero-cycle read latency.
REQ-017 SHALL give both read ports identical data when ReadReg1=ReadReg2.
REQ-018 SHALL register WriteAck as 1 on the edge after a write with RegWrite=1 and WriteReg!=0, otherwise 0; back-to-back writes SHALL hold WriteAck high continuously.
REQ-019 SHALL leave all registers unchanged on edges where RegWrite=0.
REQ-020 SHALL treat WriteReg values 29 and 31 as ordinary writable registers after reset.

Reset
REQ-021 SHALL, while reset=1, force every register to 0 except register 29=SP_INIT and register 31=RA_INIT, independent of clk.
REQ-022 SHALL force WriteAck=0 while reset=1.
REQ-023 SHALL discard a write coincident with reset assertion; the reset values win.
REQ-024 SHALL accept the first write on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, with macro REG_FILE_BYPASS_EN defined, return WriteData on a read port in the same cycle when RegWrite=1, WriteReg!=0, and the read address equals WriteReg (write-through forwarding).
REQ-026 SHALL, without REG_FILE_BYPASS_EN, return the stored pre-write value on a read port until the write edge, and the new value only afterwards.
REQ-027 SHALL never forward on register 0, with or without the macro.

Verification
REQ-028 SHALL check: assert reset, read 29, 31 and 5 -> 227, 0, 0; WriteAck=0.
REQ-029 SHALL check: RegWrite=1, WriteReg=8, WriteData=32'hDEADBEEF, one edge, ReadReg1=8 -> ReadData1=32'hDEADBEEF; WriteAck=1 for one cycle.
REQ-030 SHALL check: write 32'h12345678 to register 0 -> ReadData1/2 at address 0 read 0; WriteAck stays 0.
REQ-031 SHALL check: ReadReg2=31, RegWrite=1, WriteReg=31, WriteData=32'h400 before the edge -> ReadData2=32'h400 with REG_FILE_BYPASS_EN, the old value (0) without it; both read 32'h400 after the edge.
REQ-032 SHALL check: write 32'hAA to register 29, assert reset mid-cycle with no clk edge -> register 29 immediately reads 227.
REQ-033 SHALL check: writes to registers 1..31 with value=index on consecutive edges -> all read back correctly on both ports; WriteAck stays high through the run.
